// File: rtl/fir_pkg.sv
// Shared definitions for the streaming FIR filter: width helpers and the
// reference Gaussian coefficient set used when bringing the filter up.
package fir_pkg;

   // Ceiling log2 for sizing address and growth bits (returns 0 for 1).
   function automatic int clog2(input int value);
      int bits;
      int rem;
      bits = 0;
      rem  = value - 1;
      while (rem > 0) begin
         bits = bits + 1;
         rem  = rem >> 1;
      end
      return bits;
   endfunction

   // Accumulator width that holds the full-precision sum of all taps.
   function automatic int acc_width(input int in_w, input int coef_w, input int taps);
      return in_w + coef_w + clog2(taps);
   endfunction

   // Gaussian kernel of the original fixed 8th-order filter (sums to 256).
   localparam int GAUSS_TAPS = 9;
   localparam int GAUSS_COEF [GAUSS_TAPS] = '{7, 17, 32, 46, 52, 46, 32, 17, 7};

endpackage

// File: rtl/fir_stream_if.sv
// Sample stream bundle: input handshake from the source and output handshake
// to the consumer. The filter uses the slave view, the source/sink the master.
interface fir_stream_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [IN_W-1:0]  Data_in;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] Data_out;

   modport master (
      output in_valid, Data_in, out_ready,
      input  in_ready, out_valid, Data_out
   );

   modport slave (
      input  in_valid, Data_in, out_ready,
      output in_ready, out_valid, Data_out
   );
endinterface

// File: rtl/fir_adder_tree.sv
// Combinational signed sum of all registered tap products. Written as a
// reduction loop; synthesis balances it into a tree.
module fir_adder_tree #(
   parameter int TAPS  = 9,
   parameter int ACC_W = 36
) (
   input  logic signed [ACC_W-1:0] prods [TAPS],
   output logic signed [ACC_W-1:0] sum
);

   // Accumulate every product at full accumulator precision.
   always_comb begin
      sum = '0;
      for (int i = 0; i < TAPS; i++) begin
         sum = sum + prods[i];
      end
   end

endmodule

// File: rtl/fir_stream.sv
// Parametrised streaming FIR with run-time writable coefficients, a
// valid/ready handshake on both sides, a two-stage multiply/sum pipeline
// and a synchronous flush.
// Optional feature: define FIR_SAT_EN to saturate the output to the OUT_W
// signed range and expose a sticky sat_flag; otherwise the output wraps.
module fir_stream
   import fir_pkg::*;
#(
   parameter int TAPS   = 9,
   parameter int IN_W   = 16,
   parameter int COEF_W = 16,
   parameter int OUT_W  = 16,
   parameter int SHIFT  = 0
) (
   input  logic                      clk,
   input  logic                      Reset_n,
   input  logic                      Flush,
   input  logic                      coef_wr,
   input  logic [clog2(TAPS)-1:0]    coef_addr,
   input  logic signed [COEF_W-1:0]  coef_data,
   fir_stream_if.slave               bus
`ifdef FIR_SAT_EN
   ,
   output logic                      sat_flag
`endif
);

   localparam int ACC_W = acc_width(IN_W, COEF_W, TAPS);

   logic signed [IN_W-1:0]   line  [TAPS];
   logic signed [COEF_W-1:0] coef  [TAPS];
   logic signed [ACC_W-1:0]  prod  [TAPS];
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  acc;
   logic                     v0;
   logic                     v1;
   logic                     acc_valid;
   logic                     en;
   logic                     accept;

   // The whole pipeline advances unless a held result is waiting on the consumer.
   assign en           = !acc_valid || bus.out_ready;
   assign bus.in_ready = en && !Flush && Reset_n;
   assign accept       = bus.in_valid && bus.in_ready;
   assign bus.out_valid = acc_valid;

   // Delay line: newest sample enters slot 0 only when a sample is accepted.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < TAPS; i++) line[i] <= '0;
      end else if (Flush) begin
         for (int i = 0; i < TAPS; i++) line[i] <= '0;
      end else if (accept) begin
         for (int i = TAPS - 1; i > 0; i--) line[i] <= line[i-1];
         line[0] <= bus.Data_in;
      end
   end

   // Coefficient bank: written at any time, out-of-range addresses ignored, kept across flush.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < TAPS; i++) coef[i] <= '0;
      end else if (coef_wr && (int'(coef_addr) < TAPS)) begin
         coef[coef_addr] <= coef_data;
      end
   end

   // Stage 1: register all tap products; v0 marks that the line holds a fresh sample.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < TAPS; i++) prod[i] <= '0;
         v0 <= 1'b0;
         v1 <= 1'b0;
      end else if (Flush) begin
         for (int i = 0; i < TAPS; i++) prod[i] <= '0;
         v0 <= 1'b0;
         v1 <= 1'b0;
      end else if (en) begin
         for (int i = 0; i < TAPS; i++) prod[i] <= ACC_W'(line[i]) * ACC_W'(coef[i]);
         v0 <= accept;
         v1 <= v0;
      end
   end

   fir_adder_tree #(
      .TAPS  (TAPS),
      .ACC_W (ACC_W)
   ) u_tree (
      .prods (prod),
      .sum   (sum)
   );

   // Stage 2: accumulator register holds the filtered sample until the consumer takes it.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         acc       <= '0;
         acc_valid <= 1'b0;
      end else if (Flush) begin
         acc       <= '0;
         acc_valid <= 1'b0;
      end else if (en) begin
         acc       <= sum;
         acc_valid <= v1;
      end
   end

`ifdef FIR_SAT_EN
   // True when the value is representable in OUT_W signed bits.
   function automatic logic fits(input logic signed [ACC_W-1:0] value);
      logic signed [OUT_W-1:0] low;
      low = value[OUT_W-1:0];
      return ACC_W'(low) == value;
   endfunction

   // Clamp to the OUT_W signed range.
   function automatic logic signed [OUT_W-1:0] clamp(input logic signed [ACC_W-1:0] value);
      if (fits(value)) return value[OUT_W-1:0];
      else if (value[ACC_W-1]) return {1'b1, {(OUT_W-1){1'b0}}};
      else return {1'b0, {(OUT_W-1){1'b1}}};
   endfunction

   assign bus.Data_out = clamp(acc >>> SHIFT);

   // Sticky flag raised when a valid result entering the output register saturates.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sat_flag <= 1'b0;
      end else if (Flush) begin
         sat_flag <= 1'b0;
      end else if (en && v1 && !fits(sum >>> SHIFT)) begin
         sat_flag <= 1'b1;
      end
   end
`else
   assign bus.Data_out = OUT_W'(acc >>> SHIFT);
`endif

endmodule

// File: tb/tb_fir_stream.sv
// Self-checking bench for fir_stream: two instances (SHIFT=0 and SHIFT=8)
// share one stimulus stream; directed vectors with hand-computed results plus
// a small reference model for the back-pressure run.
module tb_fir_stream;
   import fir_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               Reset_n;
   logic               Flush;
   logic               coef_wr;
   logic [3:0]         coef_addr;
   logic signed [15:0] coef_data;
   logic               in_valid;
   logic               out_ready;
   logic signed [15:0] Data_in;

   fir_stream_if #(.IN_W(16), .OUT_W(16)) bus0 ();
   fir_stream_if #(.IN_W(16), .OUT_W(16)) bus8 ();

   assign bus0.in_valid  = in_valid;
   assign bus0.Data_in   = Data_in;
   assign bus0.out_ready = out_ready;
   assign bus8.in_valid  = in_valid;
   assign bus8.Data_in   = Data_in;
   assign bus8.out_ready = out_ready;

`ifdef FIR_SAT_EN
   logic sat0;
   logic sat8;
`endif

   fir_stream #(.TAPS(9), .IN_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(0)) dut0 (
      .clk       (clk),
      .Reset_n   (Reset_n),
      .Flush     (Flush),
      .coef_wr   (coef_wr),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .bus       (bus0)
`ifdef FIR_SAT_EN
      ,
      .sat_flag  (sat0)
`endif
   );

   fir_stream #(.TAPS(9), .IN_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(8)) dut8 (
      .clk       (clk),
      .Reset_n   (Reset_n),
      .Flush     (Flush),
      .coef_wr   (coef_wr),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .bus       (bus8)
`ifdef FIR_SAT_EN
      ,
      .sat_flag  (sat8)
`endif
   );

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int line_m [9];
   int coef_m [9] = '{7, 17, 32, 46, 52, 46, 32, 17, 7};
   bit track = 1'b0;

   int imp_exp  [10] = '{7, 17, 32, 46, 52, 46, 32, 17, 7, 0};
   int step_exp [10] = '{7, 24, 56, 102, 154, 200, 232, 249, 256, 256};

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One cycle: drive a sample, check the output handshake before the edge, then step past the edge.
   task automatic applyStimulus(input logic v, input logic signed [15:0] d);
      logic take;
      int   s;
      in_valid = v;
      Data_in  = d;
      #1;
      take = v && bus0.in_ready;
      if (track && bus0.out_valid) begin
         if (exp_q.size() == 0) checkOutput("bp_unexpected_valid", bus0.out_valid, 0);
         else if (out_ready) checkOutput("bp_data", bus0.Data_out, exp_q.pop_front());
         else checkOutput("bp_hold", bus0.Data_out, exp_q[0]);
      end
      if (take) begin
         for (int i = 8; i > 0; i--) line_m[i] = line_m[i-1];
         line_m[0] = d;
         s = 0;
         for (int i = 0; i < 9; i++) s += line_m[i] * coef_m[i];
         exp_q.push_back(s);
      end
      @(posedge clk);
      #1;
   endtask

   // Flush while offering a sample: in_ready must drop and out_valid must clear.
   task automatic doFlush();
      Flush    = 1'b1;
      in_valid = 1'b1;
      Data_in  = 16'sd3;
      #1;
      checkOutput("flush_in_ready", bus0.in_ready, 0);
      @(posedge clk);
      #1;
      Flush = 1'b0;
      for (int i = 0; i < 9; i++) line_m[i] = 0;
      exp_q.delete();
      checkOutput("flush_out_valid", bus0.out_valid, 0);
   endtask

   // Hard limit so the bench always terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected normal finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      Reset_n   = 1'b0;
      Flush     = 1'b0;
      coef_wr   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      Data_in   = 16'sd5;
      for (int i = 0; i < 9; i++) line_m[i] = 0;

      #2;
      checkOutput("reset_in_ready", bus0.in_ready, 0);
      checkOutput("reset_out_valid", bus0.out_valid, 0);
      checkOutput("reset_data_out", bus0.Data_out, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      Reset_n  = 1'b1;
      #1;
      checkOutput("ready_after_reset", bus0.in_ready, 1);

      // Load the Gaussian kernel
      for (int a = 0; a < 9; a++) begin
         coef_wr   = 1'b1;
         coef_addr = 4'(a);
         coef_data = 16'(GAUSS_COEF[a]);
         applyStimulus(1'b0, 16'sd0);
      end
      coef_wr = 1'b0;

      // Impulse response with two-cycle latency
      applyStimulus(1'b1, 16'sd1);
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b1, 16'sd0);
         if (i == 0) begin
            checkOutput("impulse_latency", bus0.out_valid, 0);
         end else begin
            checkOutput("impulse_valid", bus0.out_valid, 1);
            checkOutput($sformatf("impulse_%0d", i - 1), bus0.Data_out, imp_exp[i-1]);
         end
      end

      // Step response at SHIFT=0 and SHIFT=8
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 16'sd1);
         if (i >= 2) checkOutput($sformatf("step_%0d", i - 2), bus0.Data_out, step_exp[i-2]);
         if (i == 9) checkOutput("step_shift8_ramp", bus8.Data_out, 0);
         if (i == 11) checkOutput("step_shift8_settled", bus8.Data_out, 1);
      end

      // Flush mid-stream, then a clean impulse
      doFlush();
      applyStimulus(1'b1, 16'sd1);
      applyStimulus(1'b1, 16'sd0);
      applyStimulus(1'b1, 16'sd0);
      checkOutput("post_flush_valid", bus0.out_valid, 1);
      checkOutput("post_flush_first", bus0.Data_out, 7);
      applyStimulus(1'b1, 16'sd0);
      checkOutput("post_flush_second", bus0.Data_out, 17);

      // Back-pressure against the reference model
      doFlush();
      track = 1'b1;
      for (int i = 0; i < 24; i++) begin
         out_ready = !(i >= 8 && i < 13);
         applyStimulus(1'b1, 16'((i * 5) % 13 - 6));
         if (i >= 8 && i < 12) checkOutput("bp_in_ready", bus0.in_ready, 0);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'sd0);
      checkOutput("bp_drained", exp_q.size(), 0);
      checkOutput("bp_idle_valid", bus0.out_valid, 0);
      track = 1'b0;

      // Coefficient write during streaming
      doFlush();
      for (int i = 0; i < 11; i++) applyStimulus(1'b1, 16'sd1);
      checkOutput("coef_base", bus0.Data_out, 256);
      coef_wr   = 1'b1;
      coef_addr = 4'd4;
      coef_data = 16'sd100;
      applyStimulus(1'b1, 16'sd1);
      coef_wr = 1'b0;
      checkOutput("coef_write_edge", bus0.Data_out, 256);
      applyStimulus(1'b1, 16'sd1);
      checkOutput("coef_old_product", bus0.Data_out, 256);
      applyStimulus(1'b1, 16'sd1);
      checkOutput("coef_new_product", bus0.Data_out, 304);
      coef_wr   = 1'b1;
      coef_addr = 4'd12;
      coef_data = 16'sd999;
      applyStimulus(1'b1, 16'sd1);
      coef_wr = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'sd1);
      checkOutput("coef_out_of_range", bus0.Data_out, 304);

      // Coefficient restore coinciding with a flush, then full-scale input
      coef_wr   = 1'b1;
      coef_addr = 4'd4;
      coef_data = 16'sd52;
      doFlush();
      coef_wr = 1'b0;
`ifdef FIR_SAT_EN
      checkOutput("sat_flag_initial", sat0, 0);
`endif
      for (int i = 0; i < 11; i++) applyStimulus(1'b1, 16'sd32767);
      checkOutput("full_scale_shift8", bus8.Data_out, 32767);
`ifdef FIR_SAT_EN
      checkOutput("full_scale_sat", bus0.Data_out, 32767);
      checkOutput("sat_flag_set", sat0, 1);
      doFlush();
      checkOutput("sat_flag_flushed", sat0, 0);
`else
      checkOutput("full_scale_wrap", bus0.Data_out, -256);
`endif

      // Reset mid-stream drops samples and zeroes the coefficients
      in_valid = 1'b1;
      Data_in  = 16'sd9;
      #2;
      Reset_n = 1'b0;
      #1;
      checkOutput("midreset_out_valid", bus0.out_valid, 0);
      checkOutput("midreset_data_out", bus0.Data_out, 0);
      checkOutput("midreset_in_ready", bus0.in_ready, 0);
      #2;
      Reset_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 16'sd1);
      applyStimulus(1'b1, 16'sd0);
      applyStimulus(1'b1, 16'sd0);
      checkOutput("midreset_valid_after", bus0.out_valid, 1);
      checkOutput("midreset_zero_coef", bus0.Data_out, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_stream.md
Name: fir_stream

Overview:
- Parametrised streaming FIR filter; successor to the fixed 8th-order Gaussian FIR.
- Generic tap count, data and coefficient widths.
- Coefficients are run-time writable.
- valid/ready handshake on input and output, two-stage registered multiply/sum pipeline with back-pressure, synchronous flush.
- Sits between a sample source and a downstream consumer in the signal path.

Parameters:
- TAPS, 9, number of coefficients (filter order TAPS-1); 2..32
- IN_W, 16, signed input sample width
- COEF_W, 16, signed coefficient width
- OUT_W, 16, signed output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before output; 0..ACC_W-1

Ports:
- clk  in  1  clock; all state changes on rising edge
- Reset_n  in  1  reset, asynchronous, active-low
- Flush  in  1  synchronous clear of delay line and pipeline
- coef_wr  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  coefficient index; 0 multiplies the newest sample
- coef_data  in  COEF_W  signed coefficient value
- in_valid  in  1  Data_in valid
- in_ready  out  1  block accepts a sample this cycle
- Data_in  in  IN_W  signed sample
- out_valid  out  1  Data_out valid
- out_ready  in  1  consumer accepts Data_out
- Data_out  out  OUT_W  signed filtered sample

Behaviour:
- Reset (Reset_n=0, async):
  - delay line, coefficients, product registers and accumulator all cleared to 0.
  - out_valid=0, Data_out=0.
  - in_ready=0 while Reset_n=0.
- Accumulator width: ACC_W = IN_W+COEF_W+clog2(TAPS). All products and sums are signed, full precision, no overflow inside ACC_W.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en && !Flush.
- Accept: when in_valid && in_ready at edge k:
  - delay line shifts; slot 0 takes Data_in.
  - stage-1 registers take sample[i]*coef[i] computed from the updated line at edge k+1, with v1=1.
  - accumulator takes the sum at edge k+2, and out_valid=1.
  - Latency: 2 cycles from acceptance to out_valid.
- Bubbles: no acceptance while en=1 → a bubble enters the pipeline (v1=0); the delay line does not shift.
- Stall: en=0 → delay line, products, v1, accumulator and out_valid all hold. Data_out stays stable while out_valid=1 and out_ready=0.
- Output: Data_out = low OUT_W bits of (acc >>> SHIFT), wrapping.
- Coefficient write:
  - coef_wr at edge e updates coef[coef_addr] at e.
  - The new value is used by any product registered at e+1 or later.
  - Permitted during streaming; no handshake.
  - coef_addr >= TAPS is ignored.
- Flush=1 at an edge:
  - delay line, products and accumulator cleared; v1=0; out_valid=0.
  - Coefficients are kept.
  - Flush beats any simultaneous acceptance (in_ready is already 0) and any stall.
- Simultaneous coef_wr and Flush: both take effect.
- Reset mid-stream: all in-flight samples are lost; coefficients revert to 0.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined: after the shift, a value outside the OUT_W signed range saturates to 2^(OUT_W-1)-1 or -2^(OUT_W-1). Sticky output sat_flag (1 bit) is set on any saturated output and cleared by Flush or reset.
- Undefined: output wraps; no sat_flag port.

Decomposition:
- Package fir_pkg:
  - clog2 function
  - ACC_W derivation function
  - default Gaussian coefficient constants (7,17,32,46,52,46,32,17,7) for benches
- Sub-module fir_adder_tree: combinational signed sum of TAPS ACC_W-wide products feeding the accumulator register.
- Delay line, coefficient bank and handshake stay in fir_stream.

Test Plan:
- Impulse, TAPS=9, Gaussian coefficients loaded, SHIFT=0, out_ready=1: Data_in 1 then zeros → Data_out sequence 7,17,32,46,52,46,32,17,7,0. First value appears 2 cycles after acceptance.
- Step input of 1 held, SHIFT=8 → output ramps and settles at 1 (sum 256>>8). SHIFT=0 → settles at 256.
- Back-pressure: out_ready=0 for 5 cycles mid-stream → in_ready=0, Data_out held constant, no sample lost or duplicated versus the golden model.
- Flush during streaming with in_valid=1 → next edge out_valid=0. After the next accepted impulse, output 7 is uncorrupted by old samples. Coefficients are unchanged.
- Coefficient write coef[4]=100 mid-stream → products registered from the following cycle use 100; an out-of-range address leaves the bank unchanged.
- OUT_W=16, SHIFT=0, constant input 32767, sum 256:
  - FIR_SAT_EN defined → 32767 and sat_flag=1.
  - FIR_SAT_EN undefined → 0xFF00 (-256).
